// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back controller.
package wb_pkg;
    localparam int unsigned DATA_W           = 16;
    localparam int unsigned RADDR_W          = 4;
    localparam int unsigned NUM_REGS         = 1 << RADDR_W;
    localparam int unsigned LQ_DEPTH_DEFAULT = 4;

    typedef logic [RADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]  reg_data_t;

    localparam reg_addr_t R_ZERO = 4'd0;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_MEM,
        WB_ALU
    } wb_src_e;
endpackage

// File: rtl/wb_load_queue.sv
// In-order queue of outstanding load destinations; exposes every entry so the
// owner can build a busy scoreboard.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = LQ_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  reg_addr_t              push_dst,
    input  logic                   pop,
    output reg_addr_t              head_dst,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH-1:0]       ent_valid,
    output reg_addr_t [DEPTH-1:0]  ent_dst
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dst = ent_dst[head];

    // push_ok and pop_ok never target the same slot: a push needs a free slot,
    // a pop needs an occupied one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_dst   <= '0;
        end else begin
            if (push_ok) begin
                ent_dst[tail]   <= push_dst;
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            if (pop_ok) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/regfile_writeback.sv
// Write-port arbiter for the 16x16 register file: merges ALU results and
// in-order load returns, tracks busy registers, flags decode read hazards.
// Optional forwarding paths fwd_a/fwd_b are enabled by defining WB_BYPASS_EN.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = LQ_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      alu_valid,
    output logic      alu_ready,
    input  reg_addr_t alu_dst,
    input  reg_data_t alu_data,
    input  logic      load_issue,
    input  reg_addr_t load_dst,
    output logic      load_ready,
    input  logic      mem_valid,
    output logic      mem_ready,
    input  reg_data_t mem_data,
    input  reg_addr_t rs_a,
    input  reg_addr_t rs_b,
    output logic      hazard_a,
    output logic      hazard_b,
    output logic      write_en,
    output reg_addr_t wrData,
    output reg_data_t DataIn
`ifdef WB_BYPASS_EN
    ,
    output reg_data_t fwd_a,
    output reg_data_t fwd_b
`endif
);
    logic                       q_full;
    logic                       q_empty;
    reg_addr_t                  head_dst;
    logic [LQ_DEPTH-1:0]        ent_valid;
    reg_addr_t [LQ_DEPTH-1:0]   ent_dst;
    logic [NUM_REGS-1:0]        busy;
    logic                       mem_fire;
    logic                       alu_fire;
    wb_src_e                    src;
    logic                       nxt_we;
    reg_addr_t                  nxt_addr;
    reg_data_t                  nxt_data;
    logic                       inflight_a;
    logic                       inflight_b;

    wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk       (clk),
        .reset     (reset),
        .push      (load_issue),
        .push_dst  (load_dst),
        .pop       (mem_fire),
        .head_dst  (head_dst),
        .full      (q_full),
        .empty     (q_empty),
        .ent_valid (ent_valid),
        .ent_dst   (ent_dst)
    );

    // r0 never becomes busy: writes to it are discarded anyway.
    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            if (ent_valid[i] && ent_dst[i] != R_ZERO)
                busy[ent_dst[i]] = 1'b1;
        end
    end

    assign load_ready = ~q_full;
    assign mem_ready  = ~q_empty;
    assign mem_fire   = mem_valid & mem_ready;
    assign alu_ready  = ~mem_fire & ~busy[alu_dst];
    assign alu_fire   = alu_valid & alu_ready;

    always_comb begin
        src      = WB_NONE;
        nxt_we   = 1'b0;
        nxt_addr = R_ZERO;
        nxt_data = '0;
        if (mem_fire)
            src = WB_MEM;
        else if (alu_fire)
            src = WB_ALU;
        unique case (src)
            WB_MEM: begin
                nxt_we   = (head_dst != R_ZERO);
                nxt_addr = head_dst;
                nxt_data = mem_data;
            end
            WB_ALU: begin
                nxt_we   = (alu_dst != R_ZERO);
                nxt_addr = alu_dst;
                nxt_data = alu_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_en <= 1'b0;
            wrData   <= R_ZERO;
            DataIn   <= '0;
        end else begin
            write_en <= nxt_we;
            if (nxt_we) begin
                wrData <= nxt_addr;
                DataIn <= nxt_data;
            end
        end
    end

    assign inflight_a = write_en && (wrData == rs_a) && (rs_a != R_ZERO);
    assign inflight_b = write_en && (wrData == rs_b) && (rs_b != R_ZERO);

`ifdef WB_BYPASS_EN
    assign hazard_a = (rs_a != R_ZERO) && busy[rs_a];
    assign hazard_b = (rs_b != R_ZERO) && busy[rs_b];
    assign fwd_a    = inflight_a ? DataIn : '0;
    assign fwd_b    = inflight_b ? DataIn : '0;
`else
    assign hazard_a = ((rs_a != R_ZERO) && busy[rs_a]) || inflight_a;
    assign hazard_b = ((rs_b != R_ZERO) && busy[rs_b]) || inflight_b;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed-vector bench for regfile_writeback; inputs change on the falling
// edge and outputs are sampled 1 ns later. Honours WB_BYPASS_EN.
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_dst;
    logic [15:0] alu_data;
    logic        load_issue;
    logic [3:0]  load_dst;
    logic        load_ready;
    logic        mem_valid;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [3:0]  rs_a;
    logic [3:0]  rs_b;
    logic        hazard_a;
    logic        hazard_b;
    logic        write_en;
    logic [3:0]  wrData;
    logic [15:0] DataIn;
`ifdef WB_BYPASS_EN
    logic [15:0] fwd_a;
    logic [15:0] fwd_b;
`endif

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    regfile_writeback #(.LQ_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_dst    (alu_dst),
        .alu_data   (alu_data),
        .load_issue (load_issue),
        .load_dst   (load_dst),
        .load_ready (load_ready),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .rs_a       (rs_a),
        .rs_b       (rs_b),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b),
        .write_en   (write_en),
        .wrData     (wrData),
        .DataIn     (DataIn)
`ifdef WB_BYPASS_EN
        ,
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    logic [3:0] t5_dst [4];

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
        load_issue = 1'b0; load_dst = '0; mem_valid = 1'b0; mem_data = '0;
        rs_a = '0; rs_b = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_we",    32'(write_en),   32'd0);
        check("rst_wa",    32'(wrData),     32'd0);
        check("rst_wd",    32'(DataIn),     32'd0);
        check("rst_lrdy",  32'(load_ready), 32'd1);
        check("rst_mrdy",  32'(mem_ready),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ALU write with no loads pending
        alu_valid = 1'b1; alu_dst = 4'd3; alu_data = 16'h1234; rs_a = 4'd3;
        #1;
        check("t2_ardy", 32'(alu_ready), 32'd1);
        check("t2_hz0",  32'(hazard_a),  32'd0);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        check("t2_we", 32'(write_en), 32'd1);
        check("t2_wa", 32'(wrData),   32'd3);
        check("t2_wd", 32'(DataIn),   32'h1234);
`ifdef WB_BYPASS_EN
        check("t2_hz",  32'(hazard_a), 32'd0);
        check("t2_fwd", 32'(fwd_a),    32'h1234);
`else
        check("t2_hz",  32'(hazard_a), 32'd1);
`endif
        @(negedge clk);
        #1;
        check("t2_we_off", 32'(write_en), 32'd0);
        check("t2_hz_off", 32'(hazard_a), 32'd0);

        // WAW: ALU to r5 must wait behind the load to r5
        load_issue = 1'b1; load_dst = 4'd5;
        #1;
        check("t3_lrdy", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_issue = 1'b0; alu_valid = 1'b1; alu_dst = 4'd5; alu_data = 16'h00AA; rs_a = 4'd5;
        #1;
        check("t3_ardy0", 32'(alu_ready), 32'd0);
        check("t3_mrdy",  32'(mem_ready), 32'd1);
        check("t3_hz",    32'(hazard_a),  32'd1);
        @(negedge clk);
        #1;
        check("t3_ardy1", 32'(alu_ready), 32'd0);
        check("t3_we0",   32'(write_en),  32'd0);
        mem_valid = 1'b1; mem_data = 16'hBEEF;
        #1;
        check("t3_ardy2", 32'(alu_ready), 32'd0);
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        check("t3_we1",   32'(write_en),  32'd1);
        check("t3_wa1",   32'(wrData),    32'd5);
        check("t3_wd1",   32'(DataIn),    32'hBEEF);
        check("t3_ardy3", 32'(alu_ready), 32'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        check("t3_we2", 32'(write_en), 32'd1);
        check("t3_wa2", 32'(wrData),   32'd5);
        check("t3_wd2", 32'(DataIn),   32'h00AA);
        @(negedge clk);

        // mem and ALU offered together: mem goes first
        load_issue = 1'b1; load_dst = 4'd2;
        @(negedge clk);
        load_issue = 1'b0; mem_valid = 1'b1; mem_data = 16'h2222;
        alu_valid = 1'b1; alu_dst = 4'd7; alu_data = 16'h7777;
        #1;
        check("t4_ardy0", 32'(alu_ready), 32'd0);
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        check("t4_wa1",   32'(wrData),    32'd2);
        check("t4_wd1",   32'(DataIn),    32'h2222);
        check("t4_ardy1", 32'(alu_ready), 32'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        check("t4_wa2", 32'(wrData), 32'd7);
        check("t4_wd2", 32'(DataIn), 32'h7777);

        // Fill the queue, overflow attempt, duplicate destinations
        t5_dst[0] = 4'd1; t5_dst[1] = 4'd1; t5_dst[2] = 4'd2; t5_dst[3] = 4'd4;
        for (int i = 0; i < 4; i++) begin
            load_issue = 1'b1; load_dst = t5_dst[i];
            @(negedge clk);
        end
        load_issue = 1'b1; load_dst = 4'd9; rs_a = 4'd1; rs_b = 4'd9;
        #1;
        check("t5_full",  32'(load_ready), 32'd0);
        check("t5_hz_r1", 32'(hazard_a),   32'd1);
        @(negedge clk);
        load_issue = 1'b0;
        #1;
        check("t5_ovf_hz", 32'(hazard_b),   32'd0);
        check("t5_full2",  32'(load_ready), 32'd0);
        mem_valid = 1'b1; mem_data = 16'h1111;
        #1;
        check("t5_mrdy",     32'(mem_ready),  32'd1);
        check("t5_popfull",  32'(load_ready), 32'd0);
        @(negedge clk);
        mem_data = 16'h1112;
        #1;
        check("t5_wa1",   32'(wrData),     32'd1);
        check("t5_wd1",   32'(DataIn),     32'h1111);
        check("t5_lrdy",  32'(load_ready), 32'd1);
        check("t5_busy1", 32'(hazard_a),   32'd1);
        @(negedge clk);
        mem_valid = 1'b0; rs_b = 4'd2;
        #1;
        check("t5_wa2",   32'(wrData),   32'd1);
        check("t5_wd2",   32'(DataIn),   32'h1112);
        check("t5_hz_r2", 32'(hazard_b), 32'd1);
        @(negedge clk);
        #1;
        check("t5_r1_free", 32'(hazard_a), 32'd0);
        // pop r2 while pushing a new r2
        mem_valid = 1'b1; mem_data = 16'h2020; load_issue = 1'b1; load_dst = 4'd2;
        @(negedge clk);
        load_issue = 1'b0; mem_data = 16'h4444;
        #1;
        check("t5_wa3",  32'(wrData),    32'd2);
        check("t5_wd3",  32'(DataIn),    32'h2020);
        check("t5_mrdy2", 32'(mem_ready), 32'd1);
        @(negedge clk);
        mem_data = 16'h2B2B;
        #1;
        check("t5_wa4",     32'(wrData),   32'd4);
        check("t5_wd4",     32'(DataIn),   32'h4444);
        check("t5_r2_busy", 32'(hazard_b), 32'd1);
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        check("t5_wa5",   32'(wrData),    32'd2);
        check("t5_wd5",   32'(DataIn),    32'h2B2B);
        check("t5_empty", 32'(mem_ready), 32'd0);
        @(negedge clk);
        #1;
        check("t5_r2_free", 32'(hazard_b), 32'd0);

        // r0 destinations: handshakes complete, nothing written
        rs_a = 4'd0; alu_valid = 1'b1; alu_dst = 4'd0; alu_data = 16'hFFFF;
        #1;
        check("t6_ardy", 32'(alu_ready), 32'd1);
        check("t6_hz0",  32'(hazard_a),  32'd0);
        @(negedge clk);
        alu_valid = 1'b0; load_issue = 1'b1; load_dst = 4'd0;
        #1;
        check("t6_we_alu", 32'(write_en),   32'd0);
        check("t6_lrdy",   32'(load_ready), 32'd1);
        @(negedge clk);
        load_issue = 1'b0; mem_valid = 1'b1; mem_data = 16'hFFFF;
        #1;
        check("t6_mrdy", 32'(mem_ready), 32'd1);
        check("t6_we1",  32'(write_en),  32'd0);
        check("t6_hz1",  32'(hazard_a),  32'd0);
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        check("t6_we_mem", 32'(write_en),  32'd0);
        check("t6_mrdy0",  32'(mem_ready), 32'd0);

        // async reset with two loads queued and a write in flight
        load_issue = 1'b1; load_dst = 4'd1;
        @(negedge clk);
        load_dst = 4'd2; alu_valid = 1'b1; alu_dst = 4'd6; alu_data = 16'h6666;
        @(negedge clk);
        load_issue = 1'b0; alu_valid = 1'b0; rs_a = 4'd1; rs_b = 4'd2;
        #1;
        check("t1_we_pre", 32'(write_en),  32'd1);
        check("t1_wa_pre", 32'(wrData),    32'd6);
        check("t1_mrdy",   32'(mem_ready), 32'd1);
        check("t1_hz_pre", 32'(hazard_a),  32'd1);
        mem_valid = 1'b1; mem_data = 16'h5A5A; alu_valid = 1'b1; alu_dst = 4'd8;
        reset = 1'b1;
        #1;
        check("t1_we",   32'(write_en),   32'd0);
        check("t1_wa",   32'(wrData),     32'd0);
        check("t1_wd",   32'(DataIn),     32'd0);
        check("t1_lrdy", 32'(load_ready), 32'd1);
        check("t1_mrdy0", 32'(mem_ready), 32'd0);
        check("t1_hza",  32'(hazard_a),   32'd0);
        check("t1_hzb",  32'(hazard_b),   32'd0);
        @(negedge clk);
        reset = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        check("t1_we_post", 32'(write_en), 32'd0);
        @(negedge clk);
        #1;
        check("t1_mrdy_post", 32'(mem_ready), 32'd0);
        check("t1_we_post2",  32'(write_en),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
